// File: rtl/store_set_load_gate.sv
// Load gate behind the store-set predictor: an LFST tracks the youngest in-flight store per set,
// and an age-ordered wait buffer holds predicted-dependent loads until that store resolves or times out.
module store_set_load_gate #(
  parameter int NUM_SETS = 256,
  parameter int TAG_W    = 6,
  parameter int WQ_DEPTH = 8,
  parameter int TIMEOUT  = 63,
  localparam int SSID_W  = $clog2(NUM_SETS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              st_disp_valid,
  input  logic [SSID_W-1:0] st_disp_ssid,
  input  logic [TAG_W-1:0]  st_disp_tag,
  input  logic              st_done_valid,
  input  logic [SSID_W-1:0] st_done_ssid,
  input  logic [TAG_W-1:0]  st_done_tag,
  input  logic              ld_valid,
  output logic              ld_ready,
  input  logic [TAG_W-1:0]  ld_tag,
  input  logic [SSID_W-1:0] ld_ssid,
  input  logic              ld_pred,
  output logic              iss_valid,
  input  logic              iss_ready,
  output logic [TAG_W-1:0]  iss_tag,
  output logic [15:0]       wait_cnt,
  output logic [15:0]       timeout_cnt
);
  localparam int CNT_W = $clog2(WQ_DEPTH + 1);
  localparam int IDX_W = $clog2(WQ_DEPTH);
  localparam int AGE_W = $clog2(TIMEOUT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(TIMEOUT);

  logic [NUM_SETS-1:0] r_lfst_valid;
  logic [TAG_W-1:0]    r_lfst_tag [NUM_SETS];

  logic [TAG_W-1:0]    r_wq_tag  [WQ_DEPTH];
  logic [TAG_W-1:0]    r_wq_dtag [WQ_DEPTH];
  logic [AGE_W-1:0]    r_wq_age  [WQ_DEPTH];
  logic [WQ_DEPTH-1:0] r_wq_dep;
  logic [CNT_W-1:0]    r_count;
  logic [15:0]         r_wait_cnt;
  logic [15:0]         r_to_cnt;

  logic                w_acc, w_rel, w_new_dep, w_rel_found;
  logic [IDX_W-1:0]    w_rel_idx;
  logic [TAG_W-1:0]    w_iss_tag, w_lfst_tag;
  logic [CNT_W-1:0]    w_base, w_to_num;
  logic [TAG_W-1:0]    w_nxt_tag  [WQ_DEPTH];
  logic [TAG_W-1:0]    w_nxt_dtag [WQ_DEPTH];
  logic [AGE_W-1:0]    w_upd_age  [WQ_DEPTH];
  logic [AGE_W-1:0]    w_nxt_age  [WQ_DEPTH];
  logic [WQ_DEPTH-1:0] w_upd_dep, w_nxt_dep;

  assign ld_ready    = (r_count != CNT_W'(WQ_DEPTH)) && !flush;
  assign w_acc       = ld_valid && ld_ready;
  assign w_rel       = iss_valid && iss_ready;
  assign w_lfst_tag  = r_lfst_tag[ld_ssid];
  // A store resolving in the accept cycle already satisfies the dependency.
  assign w_new_dep   = ld_pred && r_lfst_valid[ld_ssid] &&
                       !(st_done_valid && (st_done_tag == w_lfst_tag));
  assign w_base      = r_count - CNT_W'(w_rel);
  assign iss_valid   = w_rel_found;
  assign iss_tag     = w_iss_tag;
  assign wait_cnt    = r_wait_cnt;
  assign timeout_cnt = r_to_cnt;

  // Oldest eligible entry; the scan runs young-to-old so the lowest index wins.
  always_comb begin
    w_rel_found = 1'b0;
    w_rel_idx   = '0;
    w_iss_tag   = '0;
    for (int i = WQ_DEPTH - 1; i >= 0; i--) begin
      if (i < int'(r_count) && !r_wq_dep[i]) begin
        w_rel_found = 1'b1;
        w_rel_idx   = IDX_W'(i);
        w_iss_tag   = r_wq_tag[i];
      end
    end
  end

  // Wake/timeout update per entry, then collapse over the released slot, then append.
  always_comb begin
    w_to_num  = '0;
    w_upd_dep = r_wq_dep;
    for (int i = 0; i < WQ_DEPTH; i++) begin
      w_upd_age[i] = r_wq_age[i];
      if (i < int'(r_count) && r_wq_dep[i]) begin
        if (st_done_valid && (r_wq_dtag[i] == st_done_tag)) begin
          w_upd_dep[i] = 1'b0;
        end else begin
          w_upd_age[i] = r_wq_age[i] + 1'b1;
          if (w_upd_age[i] == AGE_MAX) begin
            w_upd_dep[i] = 1'b0;
            w_to_num     = w_to_num + 1'b1;
          end
        end
      end
    end
    for (int i = 0; i < WQ_DEPTH - 1; i++) begin
      if (w_rel && (i >= int'(w_rel_idx))) begin
        w_nxt_tag[i]  = r_wq_tag[i+1];
        w_nxt_dtag[i] = r_wq_dtag[i+1];
        w_nxt_age[i]  = w_upd_age[i+1];
        w_nxt_dep[i]  = w_upd_dep[i+1];
      end else begin
        w_nxt_tag[i]  = r_wq_tag[i];
        w_nxt_dtag[i] = r_wq_dtag[i];
        w_nxt_age[i]  = w_upd_age[i];
        w_nxt_dep[i]  = w_upd_dep[i];
      end
    end
    w_nxt_tag[WQ_DEPTH-1]  = r_wq_tag[WQ_DEPTH-1];
    w_nxt_dtag[WQ_DEPTH-1] = r_wq_dtag[WQ_DEPTH-1];
    w_nxt_age[WQ_DEPTH-1]  = w_upd_age[WQ_DEPTH-1];
    w_nxt_dep[WQ_DEPTH-1]  = w_upd_dep[WQ_DEPTH-1];
    for (int i = 0; i < WQ_DEPTH; i++) begin
      if (w_acc && (i == int'(w_base))) begin
        w_nxt_tag[i]  = ld_tag;
        w_nxt_dtag[i] = w_lfst_tag;
        w_nxt_age[i]  = '0;
        w_nxt_dep[i]  = w_new_dep;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count    <= '0;
      r_wq_dep   <= '0;
      r_wait_cnt <= '0;
      r_to_cnt   <= '0;
      for (int i = 0; i < WQ_DEPTH; i++) begin
        r_wq_tag[i]  <= '0;
        r_wq_dtag[i] <= '0;
        r_wq_age[i]  <= '0;
      end
    end else if (flush) begin
      r_count  <= '0;
      r_wq_dep <= '0;
    end else begin
      r_count  <= r_count + CNT_W'(w_acc) - CNT_W'(w_rel);
      r_wq_dep <= w_nxt_dep;
      for (int i = 0; i < WQ_DEPTH; i++) begin
        r_wq_tag[i]  <= w_nxt_tag[i];
        r_wq_dtag[i] <= w_nxt_dtag[i];
        r_wq_age[i]  <= w_nxt_age[i];
      end
      if (w_acc && w_new_dep && (r_wait_cnt != 16'hFFFF)) r_wait_cnt <= r_wait_cnt + 16'd1;
      if (16'(w_to_num) > (16'hFFFF - r_to_cnt)) r_to_cnt <= 16'hFFFF;
      else r_to_cnt <= r_to_cnt + 16'(w_to_num);
    end
  end

  // Dispatch is assigned last so it wins over a same-cycle done to the same set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_lfst_valid <= '0;
    end else if (flush) begin
      r_lfst_valid <= '0;
    end else begin
      if (st_done_valid && r_lfst_valid[st_done_ssid] &&
          (r_lfst_tag[st_done_ssid] == st_done_tag)) r_lfst_valid[st_done_ssid] <= 1'b0;
      if (st_disp_valid) r_lfst_valid[st_disp_ssid] <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (st_disp_valid && !flush) r_lfst_tag[st_disp_ssid] <= st_disp_tag;
  end
endmodule
